// File: rtl/golay_coder.sv
// -----------------------------------------------------------------------------
// golay_coder
//   Sequential extended Golay (24,12) encoder for the link transmit path.
//   A 12-bit data word is captured from IDLE when enable is high. The encoder
//   then produces one parity bit per clock for 12 clocks, loads the systematic
//   codeword {data, parity}, and pulses finish for one cycle. With enable held
//   high, a new word is captured every 15 cycles.
//
// Ports
//   clk            in   1   rising-edge system clock
//   rst_n          in   1   synchronous active-low reset
//   input_vector   in  12   data word, bit 11 = MSB
//   enable         in   1   level request to encode, honoured only while ready
//   output_vector  out 24   last completed codeword, [23:12] data, [11:0] parity
//   ready          out  1   high while idle and able to accept a word
//   finish         out  1   one-cycle pulse when output_vector is updated
// -----------------------------------------------------------------------------
module golay_coder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] input_vector,
  input  logic        enable,
  output logic [23:0] output_vector,
  output logic        ready,
  output logic        finish
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Row of the parity matrix B selected by the bit counter. Counter value c
  // selects row r(c+1), which produces parity bit p[11-c].
  function automatic logic [11:0] row_mask(input logic [3:0] idx);
    logic [11:0] row;
    case (idx)
      4'd0:    row = 12'b110111000101;
      4'd1:    row = 12'b101110001011;
      4'd2:    row = 12'b011100010111;
      4'd3:    row = 12'b111000101101;
      4'd4:    row = 12'b110001011011;
      4'd5:    row = 12'b100010110111;
      4'd6:    row = 12'b000101101111;
      4'd7:    row = 12'b001011011101;
      4'd8:    row = 12'b010110111001;
      4'd9:    row = 12'b101101110001;
      4'd10:   row = 12'b011011100011;
      4'd11:   row = 12'b111111111110;
      default: row = 12'b000000000000;
    endcase
    return row;
  endfunction

  // Even-parity reduction of the masked data word.
  function automatic logic masked_parity(input logic [11:0] mask,
                                         input logic [11:0] data);
    return ^(mask & data);
  endfunction

  state_t      r_state;
  logic [11:0] r_data;
  logic [11:0] r_parity;
  logic [3:0]  r_count;
  logic [23:0] r_out;
  logic        r_ready;
  logic        r_finish;

  logic [11:0] w_row;
  logic        w_bit;

  // Parity bit for the row currently addressed by the counter.
  always_comb begin
    w_row = 12'd0;
    w_bit = 1'b0;
    if (r_state == ST_BUSY) begin
      w_row = row_mask(r_count);
      w_bit = masked_parity(w_row, r_data);
    end else begin
      w_row = 12'd0;
      w_bit = 1'b0;
    end
  end

  // Encoder state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_data   <= 12'd0;
      r_parity <= 12'd0;
      r_count  <= 4'd0;
      r_out    <= 24'd0;
      r_ready  <= 1'b1;
      r_finish <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_finish <= 1'b0;
          // The first idle edge after a completion only re-arms ready, so
          // a held enable gives a 15-cycle period with finish and ready
          // never high together.
          if (!r_ready) begin
            r_ready <= 1'b1;
          end else if (enable) begin
            r_data   <= input_vector;
            r_parity <= 12'd0;
            r_count  <= 4'd0;
            r_ready  <= 1'b0;
            r_state  <= ST_BUSY;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_BUSY: begin
          // Shift in MSB first: after 12 edges p[11] sits at bit 11.
          r_parity <= {r_parity[10:0], w_bit};
          if (r_count == 4'd11) begin
            r_count <= 4'd0;
            r_state <= ST_DONE;
          end else begin
            r_count <= r_count + 4'd1;
          end
        end

        ST_DONE: begin
          r_out    <= {r_data, r_parity};
          r_finish <= 1'b1;
          r_state  <= ST_IDLE;
        end

        default: begin
          r_state  <= ST_IDLE;
          r_count  <= 4'd0;
          r_ready  <= 1'b1;
          r_finish <= 1'b0;
        end
      endcase
    end
  end

  assign output_vector = r_out;
  assign ready         = r_ready;
  assign finish        = r_finish;

endmodule

// File: tb/tb_golay_coder.sv
module tb_golay_coder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] input_vector;
  logic        enable;
  logic [23:0] output_vector;
  logic        ready;
  logic        finish;

  golay_coder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .input_vector (input_vector),
    .enable       (enable),
    .output_vector(output_vector),
    .ready        (ready),
    .finish       (finish)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [23:0] exp_q[$];
  int sb_checks = 0;
  int sb_fail   = 0;
  int dr_checks = 0;
  int dr_fail   = 0;

  // Column-oriented reference: data bit (12-k) contributes column k of B,
  // which equals row rk because B is symmetric.
  function automatic logic [11:0] ref_parity(input logic [11:0] d);
    logic [11:0] rows [12];
    logic [11:0] p;
    rows[0]  = 12'b110111000101;
    rows[1]  = 12'b101110001011;
    rows[2]  = 12'b011100010111;
    rows[3]  = 12'b111000101101;
    rows[4]  = 12'b110001011011;
    rows[5]  = 12'b100010110111;
    rows[6]  = 12'b000101101111;
    rows[7]  = 12'b001011011101;
    rows[8]  = 12'b010110111001;
    rows[9]  = 12'b101101110001;
    rows[10] = 12'b011011100011;
    rows[11] = 12'b111111111110;
    p = 12'd0;
    for (int k = 1; k <= 12; k++) begin
      if (d[12-k]) p = p ^ rows[k-1];
    end
    return p;
  endfunction

  // Scoreboard monitor: compares every finish pulse against the queue.
  always @(negedge clk) begin
    logic [23:0] e;
    int w;
    if (finish === 1'b1) begin
      sb_checks++;
      if (exp_q.size() == 0) begin
        sb_fail++;
        $display("FAIL unexpected_finish: got 0x%06h with no codeword expected", output_vector);
      end else begin
        e = exp_q.pop_front();
        if (output_vector !== e) begin
          sb_fail++;
          $display("FAIL codeword: got 0x%06h expected 0x%06h", output_vector, e);
        end
      end
      sb_checks++;
      w = $countones(output_vector);
      if (!(w == 0 || w == 8 || w == 12 || w == 16 || w == 24)) begin
        sb_fail++;
        $display("FAIL weight: got %0d expected one of 0/8/12/16/24", w);
      end
      sb_checks++;
      if (ready !== 1'b0) begin
        sb_fail++;
        $display("FAIL ready_with_finish: got ready=%b expected 0", ready);
      end
    end
  end

  task automatic dcheck(input string name, input logic [31:0] act, input logic [31:0] exp);
    dr_checks++;
    if (act !== exp) begin
      dr_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    dcheck("ready_wait", ready, 1);
  endtask

  // Issue one word at an idle edge; the caller decides whether enable stays up.
  task automatic start_word(input logic [11:0] d, input logic [23:0] e, input logic keep_en);
    wait_ready();
    input_vector = d;
    enable       = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    if (!keep_en) enable = 1'b0;
  endtask

  // Counts negedges starting from the one right after the capture edge.
  task automatic wait_finish(output int lat);
    lat = 1;
    while (finish !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    dcheck("finish_wait", finish, 1);
  endtask

  logic [11:0] uv_in  [4] = '{12'h001, 12'h800, 12'hFFF, 12'h000};
  logic [23:0] uv_exp [4] = '{24'h001FFE, 24'h800DC5, 24'hFFFFFF, 24'h000000};

  initial begin
    int lat;
    int t0;
    int t1;
    int n;
    logic [11:0] d;

    rst_n        = 1'b0;
    enable       = 1'b0;
    input_vector = 12'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dcheck("reset_out", output_vector, 24'h000000);
    dcheck("reset_ready", ready, 1);
    dcheck("reset_finish", finish, 0);
    repeat (20) @(negedge clk);
    dcheck("idle_ready", ready, 1);
    dcheck("idle_out", output_vector, 24'h000000);

    // Single encode with latency check.
    start_word(12'h0F0, 24'h0F075E, 1'b0);
    wait_finish(lat);
    dcheck("latency", lat, 14);
    @(negedge clk);
    dcheck("ready_after", ready, 1);
    dcheck("finish_drop", finish, 0);
    dcheck("out_hold", output_vector, 24'h0F075E);

    // Unit vectors and the all-zero word.
    for (int i = 0; i < 4; i++) begin
      start_word(uv_in[i], uv_exp[i], 1'b0);
      wait_finish(lat);
      dcheck("unit_latency", lat, 14);
    end

    // Input change during the third busy cycle must be ignored.
    start_word(12'h0F0, 24'h0F075E, 1'b0);
    repeat (2) @(negedge clk);
    input_vector = 12'hFFF;
    enable       = 1'b1;
    wait_finish(lat);
    enable       = 1'b0;
    input_vector = 12'h000;
    repeat (3) @(negedge clk);

    // Continuous enable: one codeword every 15 cycles.
    wait_ready();
    input_vector = 12'h0F0;
    enable       = 1'b1;
    repeat (3) exp_q.push_back(24'h0F075E);
    wait_finish(lat);
    t0 = cyc;
    @(negedge clk);
    wait_finish(lat);
    t1 = cyc;
    dcheck("period1", t1 - t0, 15);
    @(negedge clk);
    wait_finish(lat);
    t0 = cyc;
    dcheck("period2", t0 - t1, 15);

    // Reset in the middle of the next encode aborts it.
    repeat (6) @(negedge clk);
    dcheck("busy_before_reset", ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b0;
    dcheck("abort_out", output_vector, 24'h000000);
    dcheck("abort_ready", ready, 1);
    repeat (20) @(negedge clk);
    dcheck("abort_finish", finish, 0);
    dcheck("abort_out_hold", output_vector, 24'h000000);

    // Back-to-back sweep against the reference model.
    for (int i = 0; i < 200; i++) begin
      d = 12'($urandom_range(0, 4095));
      start_word(d, {d, ref_parity(d)}, 1'b1);
    end
    enable = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    dcheck("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", sb_checks + dr_checks, sb_fail + dr_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
